// File: rtl/id_pkg.sv
// Shared decode types for the WISC instruction-decode stage: opcodes, control
// bundle, fixed register roles and the opcode-to-control decoder.
package id_pkg;

    localparam int DATA_REG = 14;
    localparam int LINK_REG = 15;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_NOR = 4'h3,
        OP_SLL  = 4'h4, OP_SRL  = 4'h5, OP_SRA  = 4'h6, OP_ADDI = 4'h7,
        OP_LW   = 4'h8, OP_SW   = 4'h9, OP_LHB  = 4'hA, OP_LLB = 4'hB,
        OP_B    = 4'hC, OP_CALL = 4'hD, OP_RET  = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_S4   = 2'd1,
        IMM_S8   = 2'd2,
        IMM_Z8   = 2'd3
    } imm_sel_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_to_mem;
        logic       reg_write;
        logic       branch;
        logic       call;
        logic       ret;
        logic       rs_used;
        logic       rt_used;
        imm_sel_e   imm_sel;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input opcode_e op);
        ctrl_t      c;
        logic [3:0] op_bits;
        c       = '0;
        op_bits = op;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_NOR: begin
                c.alu_op    = op_bits[2:0];
                c.reg_write = 1'b1;
                c.rs_used   = 1'b1;
                c.rt_used   = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA, OP_ADDI: begin
                c.alu_op    = op_bits[2:0];
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.rs_used   = 1'b1;
                c.imm_sel   = IMM_S4;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.rs_used    = 1'b1;
                c.imm_sel    = IMM_S8;
            end
            OP_SW: begin
                c.alu_src    = 1'b1;
                c.reg_to_mem = 1'b1;
                c.rs_used    = 1'b1;
                c.rt_used    = 1'b1;
                c.imm_sel    = IMM_S8;
            end
            OP_LHB, OP_LLB: begin
                c.alu_op    = 3'b111;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.rs_used   = 1'b1;
                c.imm_sel   = IMM_Z8;
            end
            OP_B: begin
                c.branch  = 1'b1;
                c.imm_sel = IMM_S8;
            end
            OP_CALL: begin
                c.call      = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_RET: begin
                c.ret     = 1'b1;
                c.rs_used = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with R0 hardwired to zero and same-cycle
// write-through so decode sees the value being written back.
module regfile_bypass #(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 16,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RW-1:0]     raddr_a,
    input  logic [RW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_r [NREGS];

    // Register storage: synchronous clear, writes to R0 discarded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port A with write-through bypass
    always_comb begin
        rdata_a = '0;
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = regs_r[raddr_a];
        end
    end

    // Read port B with write-through bypass
    always_comb begin
        rdata_b = '0;
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = regs_r[raddr_b];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// WISC instruction-decode stage: field extraction, operand read, load-use
// interlock and the registered ID/EX boundary with valid/ready and flush.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int NREGS   = 16,
    parameter  int INSTR_W = 16,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  pc_in,
    output logic               id_ready,
    input  logic               ex_ready,
    input  logic               flush,
    input  logic               wb_we,
    input  logic [RW-1:0]      wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [RW-1:0]      ex_rs,
    output logic [RW-1:0]      ex_rt,
    output logic [RW-1:0]      ex_rd,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [2:0]         ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_mem_to_reg,
    output logic               ex_reg_to_mem,
    output logic               ex_reg_write,
    output logic               ex_branch,
    output logic               ex_call,
    output logic               ex_ret,
    output logic [2:0]         ex_cond,
    output logic [11:0]        ex_call_tgt,
    output logic               halt
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [RW-1:0]     rs;
        logic [RW-1:0]     rt;
        logic [RW-1:0]     rd;
        logic [DATA_W-1:0] imm;
        logic [2:0]        alu_op;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_to_mem;
        logic              reg_write;
        logic              branch;
        logic              call;
        logic              ret;
        logic [2:0]        cond;
        logic [11:0]       call_tgt;
    } idex_t;

    opcode_e           op_s;
    ctrl_t             ctrl_s;
    logic [RW-1:0]     rs_s, rt_s, rd_s;
    logic [DATA_W-1:0] imm_s, rs_data_s, rt_data_s;
    logic              adv_s, hazard_s, accept_s;
    idex_t             idex_d_s, ex_r;
    logic              halt_r;

    assign op_s   = opcode_e'(instr[15:12]);
    assign ctrl_s = decode_ctrl(op_s);

    // Register-index selection per instruction class
    always_comb begin
        rs_s = '0;
        rt_s = '0;
        rd_s = '0;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_NOR: begin
                rd_s = RW'(instr[11:8]);
                rs_s = RW'(instr[7:4]);
                rt_s = RW'(instr[3:0]);
            end
            OP_SLL, OP_SRL, OP_SRA, OP_ADDI: begin
                rd_s = RW'(instr[11:8]);
                rs_s = RW'(instr[7:4]);
            end
            OP_LW: begin
                rd_s = RW'(instr[11:8]);
                rs_s = RW'(DATA_REG);
            end
            OP_SW: begin
                rt_s = RW'(instr[11:8]);
                rs_s = RW'(DATA_REG);
            end
            OP_LHB, OP_LLB: begin
                rd_s = RW'(instr[11:8]);
                rs_s = RW'(instr[11:8]);
            end
            OP_CALL: rd_s = RW'(LINK_REG);
            OP_RET:  rs_s = RW'(LINK_REG);
            default: begin
                rs_s = '0;
                rt_s = '0;
                rd_s = '0;
            end
        endcase
    end

    // Immediate extension
    always_comb begin
        imm_s = '0;
        case (ctrl_s.imm_sel)
            IMM_S4:  imm_s = {{(DATA_W-4){instr[3]}}, instr[3:0]};
            IMM_S8:  imm_s = {{(DATA_W-8){instr[7]}}, instr[7:0]};
            IMM_Z8:  imm_s = {{(DATA_W-8){1'b0}}, instr[7:0]};
            default: imm_s = '0;
        endcase
    end

    regfile_bypass #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs_s),
        .raddr_b (rt_s),
        .rdata_a (rs_data_s),
        .rdata_b (rt_data_s)
    );

    // A load in EX whose destination feeds this instruction costs one bubble
    assign adv_s    = !ex_r.valid || ex_ready;
    assign hazard_s = if_valid && ex_r.valid && ex_r.mem_to_reg && (ex_r.rd != '0) &&
                      ((ctrl_s.rs_used && (rs_s == ex_r.rd)) ||
                       (ctrl_s.rt_used && (rt_s == ex_r.rd)));
    assign id_ready = rst_n && !halt_r && adv_s && !hazard_s;
    assign accept_s = if_valid && id_ready;

    // Next ID/EX contents for an accepted instruction
    always_comb begin
        idex_d_s            = '0;
        idex_d_s.valid      = 1'b1;
        idex_d_s.pc         = pc_in;
        idex_d_s.rs_data    = rs_data_s;
        idex_d_s.rt_data    = rt_data_s;
        idex_d_s.rs         = rs_s;
        idex_d_s.rt         = rt_s;
        idex_d_s.rd         = rd_s;
        idex_d_s.imm        = imm_s;
        idex_d_s.alu_op     = ctrl_s.alu_op;
        idex_d_s.alu_src    = ctrl_s.alu_src;
        idex_d_s.mem_to_reg = ctrl_s.mem_to_reg;
        idex_d_s.reg_to_mem = ctrl_s.reg_to_mem;
        idex_d_s.reg_write  = ctrl_s.reg_write;
        idex_d_s.branch     = ctrl_s.branch;
        idex_d_s.call       = ctrl_s.call;
        idex_d_s.ret        = ctrl_s.ret;
        if (ctrl_s.branch) begin
            idex_d_s.cond = instr[11:9];
        end else begin
            idex_d_s.cond = 3'b000;
        end
        if (ctrl_s.call) begin
            idex_d_s.call_tgt = instr[11:0];
        end else begin
            idex_d_s.call_tgt = 12'h000;
        end
    end

    // ID/EX register and sticky halt; bubbles and flushes clear every control bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_r   <= '0;
            halt_r <= 1'b0;
        end else begin
            if (flush || (adv_s && !accept_s)) begin
                ex_r <= '0;
            end else if (adv_s) begin
                ex_r <= idex_d_s;
            end else begin
                ex_r <= ex_r;
            end
            if (accept_s && !flush && (op_s == OP_HLT)) begin
                halt_r <= 1'b1;
            end
        end
    end

    assign ex_valid      = ex_r.valid;
    assign ex_pc         = ex_r.pc;
    assign ex_rs_data    = ex_r.rs_data;
    assign ex_rt_data    = ex_r.rt_data;
    assign ex_rs         = ex_r.rs;
    assign ex_rt         = ex_r.rt;
    assign ex_rd         = ex_r.rd;
    assign ex_imm        = ex_r.imm;
    assign ex_alu_op     = ex_r.alu_op;
    assign ex_alu_src    = ex_r.alu_src;
    assign ex_mem_to_reg = ex_r.mem_to_reg;
    assign ex_reg_to_mem = ex_r.reg_to_mem;
    assign ex_reg_write  = ex_r.reg_write;
    assign ex_branch     = ex_r.branch;
    assign ex_call       = ex_r.call;
    assign ex_ret        = ex_r.ret;
    assign ex_cond       = ex_r.cond;
    assign ex_call_tgt   = ex_r.call_tgt;
    assign halt          = halt_r;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised next-generation instruction-decode stage for the WISC pipeline.
- Contents: register file with write-through bypass, opcode decode, immediate sign/zero extension, load-use hazard detection, and the registered ID/EX pipeline boundary.
- Handshake: valid/ready with IF and EX, plus flush from EX on taken branch/call/ret.
- Sits between IF/ID register and EX unit.

Parameters:
- DATA_W, 16, register/datapath width (>=16).
- NREGS, 16, register count (power of 2, >=16); reg index width RW = log2(NREGS).
- INSTR_W, 16, instruction width; fields below are fixed at bits [15:0].

Ports:
- clk  in  1  global clock.
- rst_n  in  1  synchronous active-low reset.
- if_valid  in  1  instr/pc_in valid.
- instr  in  INSTR_W  instruction from IF/ID.
- pc_in  in  DATA_W  PC of instr.
- id_ready  out  1  stage accepts instr this cycle.
- ex_ready  in  1  EX accepts ID/EX contents.
- flush  in  1  kill in-flight decode and ID/EX contents.
- wb_we  in  1  writeback enable.
- wb_rd  in  RW  writeback register.
- wb_data  in  DATA_W  writeback data.
- ex_valid  out  1  ID/EX entry valid.
- ex_pc  out  DATA_W  registered PC.
- ex_rs_data, ex_rt_data  out  DATA_W each  operands.
- ex_rs, ex_rt, ex_rd  out  RW each  register indices (for forwarding).
- ex_imm  out  DATA_W  extended immediate.
- ex_alu_op  out  3  ALU op.
- ex_alu_src  out  1  use ex_imm as operand B.
- ex_mem_to_reg, ex_reg_to_mem, ex_reg_write  out  1 each  LW, SW, register write.
- ex_branch, ex_call, ex_ret  out  1 each  PC-control class.
- ex_cond  out  3  branch condition.
- ex_call_tgt  out  12  call target.
- halt  out  1  sticky halt.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All ex_* outputs become 0; halt=0.
  - All registers clear to 0.
  - id_ready=0 during reset.
- Decode by instr[15:12]:
  - 0000-0011 (ADD, SUB, AND, NOR): rd=[11:8], rs=[7:4], rt=[3:0], alu_src=0.
  - 0100-0110 (SLL, SRL, SRA) and 0111 (ADDI): rd=[11:8], rs=[7:4], imm4 [3:0] sign-extended, alu_src=1.
  - alu_op=opcode[2:0] for 0000-0111.
  - 1000 LW: rd=[11:8], rs=DATA_REG, imm8 sign-extended, alu_op=000, alu_src=1.
  - 1001 SW: rt=[11:8] (store data), rs=DATA_REG, imm8 sign-extended, alu_op=000, alu_src=1.
  - 1010 LHB / 1011 LLB: rd=rs=[11:8], imm8 zero-extended, alu_op=111, alu_src=1.
  - 1100 B: cond=[11:9], imm8 sign-extended.
  - 1101 CALL: call_tgt=[11:0], reg_write=1, rd=LINK_REG.
  - 1110 RET: rs=LINK_REG.
  - 1111 HLT: no other control asserted.
- Register file:
  - R0 always reads 0; writes to R0 are ignored.
  - Write happens at posedge when wb_we=1.
  - Same-cycle read of wb_rd (nonzero, wb_we=1) returns wb_data (write-through).
- Stage control:
  - adv = !ex_valid || ex_ready.
  - hazard = if_valid && ex_valid && ex_mem_to_reg && ex_rd!=0 && ((rs_used && rs==ex_rd) || (rt_used && rt==ex_rd)).
    - rs_used: opcodes 0000-1011 and 1110.
    - rt_used: opcodes 0000-0011 and 1001.
  - id_ready = !halt && adv && !hazard.
  - Accept = if_valid && id_ready.
- Priority, evaluated each posedge:
  1. flush: ex_valid<=0, and instr is dropped even if accepted.
  2. adv && accept: ID/EX loads the decoded instr, ex_valid<=1.
  3. adv && !accept: bubble, ex_valid<=0; other ex_* are don't-care but must not assert any control with ex_valid=0.
  4. !adv: hold all ex_*.
- Latency: 1 cycle from accept to ex_valid.
- Load-use costs exactly one bubble.
- halt is set on accept of HLT (not flushed in the same cycle); it is sticky until reset and forces id_ready=0.
- Reset mid-stall or mid-hazard: reset wins and discards all state.

Decomposition:
- Package id_pkg:
  - opcode_e enum.
  - ctrl_t struct (alu_op, alu_src, mem_to_reg, reg_to_mem, reg_write, branch, call, ret, rs_used, rt_used, imm_sel).
  - Constants DATA_REG=14, LINK_REG=15.
  - Decode function opcode->ctrl_t.
- Sub-module regfile_bypass: parametrised on DATA_W/NREGS; two read ports, one write port, R0 hardwired, write-through.

Test Plan:
- WB-load R1=5, R2=7; issue ADD R3,R1,R2 (0x0312) -> next cycle ex_valid=1, rs_data=5, rt_data=7, rd=3, alu_op=000, alu_src=0.
- wb_we=1, wb_rd=1, wb_data=0x1234 in the same cycle ADD R3,R1,R2 is accepted -> ex_rs_data=0x1234; ADDI imm4=0xE -> ex_imm=0xFFFE.
- LW R4 then ADD R5,R4,R1 back-to-back -> id_ready=0 one cycle, one ex_valid=0 bubble, then ADD issued with rs=4.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* held constant, id_ready=0; when ex_ready=1, next instr issues.
- flush=1 with if_valid=1 during a stall -> ex_valid=0 next cycle, no halt, no ex_reg_write.
- HLT accepted -> halt=1, id_ready=0 persists 10 cycles; WB write to R0=0xFFFF then read R0 -> 0; rst_n=0 clears halt and registers.
